stream_rr_merge: RTL and testbench
==================================

Name: stream_rr_merge

Overview:
- Merges N_CH stb/ack producer streams into one stb/ack consumer stream, using round-robin arbitration with a configurable burst hold.
- Tags each output word with its source channel index.
- Aggregates per-channel exception flags into a sticky, maskable, clearable exception register.
- Placed in the user_design top level between several producer processes and one shared sink, such as rs232_tx or eth_tx.

Parameters:
- N_CH, 4, number of input channels (2..16).
- DATA_W, 32, data width of every stream.
- BURST, 1, maximum consecutive words granted to one channel before rotating (1..255). 1 gives pure round-robin.
- ID_W, derived clog2(N_CH) (minimum 1), local, width of the channel tag.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- input_in  in  N_CH*DATA_W  flattened input data; channel i occupies bits [i*DATA_W +: DATA_W].
- input_in_stb  in  N_CH  per-channel strobe.
- input_in_ack  out  N_CH  per-channel acknowledge.
- output_out  out  DATA_W  merged data.
- output_out_id  out  ID_W  source channel of output_out.
- output_out_stb  out  1  output strobe.
- output_out_ack  in  1  output acknowledge.
- exception_in  in  N_CH  per-channel exception from the producer processes.
- exception_mask  in  N_CH  1 = ignore that channel's exception.
- exception_clr  in  1  one-cycle pulse that clears the sticky exception flags.
- exception_src  out  N_CH  sticky per-channel exception flags.
- exception  out  1  OR of exception_src, registered.

Behaviour:
- Transfer rule: a word moves on any channel in a cycle where stb and ack are both high. Producers hold data and stb until they see ack.
- Reset (rst=0, asynchronous) clears:
  - input_in_ack, output_out, output_out_id, output_out_stb, exception_src, exception to 0.
  - state to IDLE, burst_cnt to 0, last_grant to N_CH-1, so channel 0 has priority first.
- Reset mid-operation discards any held word. The producer of that word has already seen its ack, so the word is lost by design.
- FSM state IDLE:
  - The winner is selected combinationally from input_in_stb.
  - If input_in_stb[last_grant] is set and burst_cnt < BURST, last_grant wins again.
  - Otherwise the first set bit scanning last_grant+1 .. last_grant+N_CH (mod N_CH) wins. On a rotation burst_cnt resets to 0.
  - input_in_ack[winner] is driven high combinationally in the same cycle.
  - On that edge: output_out <= winner data; output_out_id <= winner; last_grant <= winner; burst_cnt <= burst_cnt+1 (saturating at BURST); go to SEND.
  - If no stb is set, all acks stay low and the state stays IDLE.
- FSM state SEND:
  - output_out_stb = 1 and all input_in_ack = 0.
  - output_out and output_out_id are held stable until output_out_ack.
  - On output_out_ack: return to IDLE; output_out_stb is low in the next cycle.
- Timing:
  - Latency from stb to output_out_stb is 1 cycle.
  - Peak throughput is 1 word per 2 cycles with output_out_ack tied high.
- At most one input_in_ack bit is ever high, and only in IDLE.
- Each exception_src[i] bit, per cycle:
  - Sets when exception_in[i] & ~exception_mask[i] is high.
  - Clears on exception_clr when that set condition is low; set wins when both occur in the same cycle.
  - Otherwise holds its value.
- exception <= |exception_src, one cycle behind exception_src.
- Setting a mask bit does not clear an already-set flag.
- last_grant wraps from N_CH-1 to 0 via the modulo scan.
- burst_cnt never exceeds BURST.

Decomposition:
- Shared package stream_pkg holds:
  - the clog2 function;
  - the state encoding constants IDLE=0, SEND=1;
  - the default DATA_W.
- One sub-module, rr_arbiter: purely combinational winner selection (inputs: req, last_grant, hold_ok; outputs: grant one-hot, grant_idx, any). The FSM, registers and exception logic stay in stream_rr_merge.

Test Plan:
- Single channel: N_CH=4, BURST=1, channel 2 sends 0xDEADBEEF with output_out_ack high. Required: ack[2] pulses one cycle; next cycle output_out=0xDEADBEEF, id=2, stb=1; stb low the cycle after.
- Fairness: all 4 channels stb continuously, BURST=1. Required: output ids 0,1,2,3,0,1,... with each channel acked exactly once per 4 words.
- Burst hold: BURST=3, channels 0 and 1 continuously requesting. Required: ids 0,0,0,1,1,1,0,...; if channel 0 drops stb after 1 word, channel 1 is granted immediately.
- Backpressure: output_out_ack low for 10 cycles while in SEND. Required: output_out and id stable, every input_in_ack low, and no new word accepted until ack.
- Exceptions:
  - exception_in[1] pulse with mask=0 → exception_src=0b0010, exception high one cycle later.
  - exception_in[3] with mask[3]=1 → no change.
  - exception_clr coincident with exception_in[1] → flag stays set.
  - exception_clr alone → flags clear.
- Reset during SEND (rst low asynchronously for 2 cycles). Required: outputs go to 0 immediately; after release channel 0 wins first when all channels request.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared definitions for the stream merge block.
//   clog2          : ceiling log2 helper used to size channel tags
//   state_e        : merge FSM encoding (IDLE=0, SEND=1)
//   DEFAULT_DATA_W : default stream data width
package stream_pkg;

   localparam int unsigned DEFAULT_DATA_W = 32;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner selection with optional hold of the previous winner.
//   req        in  N_CH  request vector
//   last_grant in  ID_W  index granted last time
//   hold_ok    in  1     previous winner may be granted again if it still requests
//   grant      out N_CH  one-hot grant (all zero when nothing requests)
//   grant_idx  out ID_W  index of the granted channel
//   any        out 1     some channel was granted
module rr_arbiter #(
   parameter int unsigned N_CH = 4,
   parameter int unsigned ID_W = 2
) (
   input  logic [N_CH-1:0] req,
   input  logic [ID_W-1:0] last_grant,
   input  logic            hold_ok,
   output logic [N_CH-1:0] grant,
   output logic [ID_W-1:0] grant_idx,
   output logic            any
);

   logic [ID_W-1:0] cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      cand      = '0;
      if (hold_ok && req[last_grant]) begin
         grant_idx = last_grant;
         any       = 1'b1;
      end else begin
         // Scan last_grant+1 .. last_grant+N_CH so last_grant itself has lowest priority.
         for (int k = 1; k <= int'(N_CH); k++) begin
            cand = ID_W'((int'(last_grant) + k) % int'(N_CH));
            if (!any && req[cand]) begin
               grant_idx = cand;
               any       = 1'b1;
            end
         end
      end
      if (any) begin
         grant[grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/stream_rr_merge.sv
// Round-robin merge of N_CH stb/ack producer streams into one tagged consumer stream,
// plus a sticky, maskable, clearable exception register.
//   clk, rst            clock (rising) and asynchronous active-low reset
//   input_in            N_CH*DATA_W  flattened producer data, channel i at [i*DATA_W +: DATA_W]
//   input_in_stb/ack    N_CH         per-channel handshake
//   output_out(_id)     DATA_W/ID_W  merged word and its source channel
//   output_out_stb/ack  1            consumer handshake
//   exception_in/mask   N_CH         per-channel exception and ignore mask
//   exception_clr       1            clears sticky flags
//   exception_src       N_CH         sticky flags
//   exception           1            registered OR of exception_src
module stream_rr_merge
   import stream_pkg::*;
#(
   parameter int unsigned N_CH    = 4,
   parameter int unsigned DATA_W  = DEFAULT_DATA_W,
   parameter int unsigned BURST   = 1,
   localparam int unsigned ID_W   = (clog2(N_CH) < 1) ? 1 : clog2(N_CH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_CH*DATA_W-1:0] input_in,
   input  logic [N_CH-1:0]        input_in_stb,
   output logic [N_CH-1:0]        input_in_ack,
   output logic [DATA_W-1:0]      output_out,
   output logic [ID_W-1:0]        output_out_id,
   output logic                   output_out_stb,
   input  logic                   output_out_ack,
   input  logic [N_CH-1:0]        exception_in,
   input  logic [N_CH-1:0]        exception_mask,
   input  logic                   exception_clr,
   output logic [N_CH-1:0]        exception_src,
   output logic                   exception
);

   localparam logic [7:0] BURST_C = 8'(BURST);

   state_e            state_q, state_d;
   logic [ID_W-1:0]   last_grant_q;
   logic [7:0]        burst_cnt_q, burst_cnt_d;
   logic              hold_ok, hold, any, accept;
   logic [N_CH-1:0]   grant;
   logic [ID_W-1:0]   grant_idx;
   logic [DATA_W-1:0] win_data;
   logic [N_CH-1:0]   exc_set;

   // burst_cnt is zero only straight out of reset, so the reset value of last_grant
   // can never win by holding and channel 0 gets first priority.
   assign hold_ok = (burst_cnt_q != 8'd0) && (burst_cnt_q < BURST_C);
   assign hold    = hold_ok && input_in_stb[last_grant_q];
   assign accept  = (state_q == IDLE) && any;

   rr_arbiter #(
      .N_CH (N_CH),
      .ID_W (ID_W)
   ) u_arb (
      .req        (input_in_stb),
      .last_grant (last_grant_q),
      .hold_ok    (hold_ok),
      .grant      (grant),
      .grant_idx  (grant_idx),
      .any        (any)
   );

   always_comb begin
      win_data = '0;
      for (int i = 0; i < int'(N_CH); i++) begin
         if (grant[i]) begin
            win_data = input_in[i*DATA_W +: DATA_W];
         end
      end
   end

   // A rotation restarts the count, so the new owner has used one slot.
   always_comb begin
      burst_cnt_d = 8'd1;
      if (hold) begin
         burst_cnt_d = (burst_cnt_q < BURST_C) ? burst_cnt_q + 8'd1 : burst_cnt_q;
      end
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (any) state_d = SEND;
         SEND:    if (output_out_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM: outputs; acks are masked while reset is asserted
   always_comb begin
      input_in_ack   = '0;
      output_out_stb = 1'b0;
      unique case (state_q)
         IDLE:    if (rst) input_in_ack = grant;
         SEND:    output_out_stb = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         output_out    <= '0;
         output_out_id <= '0;
         last_grant_q  <= ID_W'(N_CH - 1);
         burst_cnt_q   <= 8'd0;
      end else if (accept) begin
         output_out    <= win_data;
         output_out_id <= grant_idx;
         last_grant_q  <= grant_idx;
         burst_cnt_q   <= burst_cnt_d;
      end
   end

   // Set wins over clear; the mask only gates new sets.
   assign exc_set = exception_in & ~exception_mask;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         exception_src <= '0;
         exception     <= 1'b0;
      end else begin
         exception_src <= exc_set | (exception_src & ~{N_CH{exception_clr}});
         exception     <= |exception_src;
      end
   end

endmodule

// File: tb/tb_stream_rr_merge.sv
// Directed self-checking bench: one instance with BURST=1 and one with BURST=3 share stimulus.
module tb_stream_rr_merge;

   localparam int unsigned N = 4;
   localparam int unsigned W = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic [N*W-1:0] input_in;
   logic [N-1:0]   input_in_stb, exception_in, exception_mask;
   logic           output_out_ack, exception_clr;
   logic [N-1:0]   ack1, ack3, src1, src3;
   logic [W-1:0]   out1, out3;
   logic [1:0]     id1, id3;
   logic           stb1, stb3, exc1, exc3;

   int unsigned passed = 0;
   int unsigned failed = 0;
   int unsigned total  = 0;
   int unsigned ack_cnt [N];
   int          exp1 [8];
   int          exp3 [8];

   always #5 clk = ~clk;

   stream_rr_merge #(.N_CH(N), .DATA_W(W), .BURST(1)) dut1 (
      .clk            (clk),
      .rst            (rst),
      .input_in       (input_in),
      .input_in_stb   (input_in_stb),
      .input_in_ack   (ack1),
      .output_out     (out1),
      .output_out_id  (id1),
      .output_out_stb (stb1),
      .output_out_ack (output_out_ack),
      .exception_in   (exception_in),
      .exception_mask (exception_mask),
      .exception_clr  (exception_clr),
      .exception_src  (src1),
      .exception      (exc1)
   );

   stream_rr_merge #(.N_CH(N), .DATA_W(W), .BURST(3)) dut3 (
      .clk            (clk),
      .rst            (rst),
      .input_in       (input_in),
      .input_in_stb   (input_in_stb),
      .input_in_ack   (ack3),
      .output_out     (out3),
      .output_out_id  (id3),
      .output_out_stb (stb3),
      .output_out_ack (output_out_ack),
      .exception_in   (exception_in),
      .exception_mask (exception_mask),
      .exception_clr  (exception_clr),
      .exception_src  (src3),
      .exception      (exc3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b1;
      input_in       = '0;
      input_in_stb   = '0;
      output_out_ack = 1'b1;
      exception_in   = '0;
      exception_mask = '0;
      exception_clr  = 1'b0;
      #1 rst = 1'b0;
      tick();
      tick();
      chk("rst_stb", 32'(stb1), 0);
      chk("rst_out", out1, 0);
      chk("rst_id", 32'(id1), 0);
      chk("rst_src", 32'(src1), 0);
      chk("rst_exc", 32'(exc1), 0);
      chk("rst_ack", 32'(ack1), 0);
      rst = 1'b1;

      // Single word on channel 2
      input_in[2*W +: W] = 32'hDEADBEEF;
      input_in_stb       = 4'b0100;
      #1;
      chk("single_ack", 32'(ack1), 32'h4);
      chk("single_ack_b3", 32'(ack3), 32'h4);
      tick();
      input_in_stb = '0;
      #1;
      chk("single_stb", 32'(stb1), 1);
      chk("single_data", out1, 32'hDEADBEEF);
      chk("single_id", 32'(id1), 2);
      chk("single_send_ack", 32'(ack1), 0);
      tick();
      chk("single_stb_low", 32'(stb1), 0);
      chk("single_idle_ack", 32'(ack1), 0);

      // Fairness (BURST=1) and burst hold over all channels (BURST=3)
      for (int i = 0; i < int'(N); i++) input_in[i*W +: W] = 32'h1000 + 32'(i);
      exp1 = '{3, 0, 1, 2, 3, 0, 1, 2};
      exp3 = '{2, 2, 3, 3, 3, 0, 0, 0};
      input_in_stb = 4'b1111;
      #1;
      for (int w = 0; w < 8; w++) begin
         chk("fair_ack", 32'(ack1), 32'(1) << exp1[w]);
         chk("burst_all_ack", 32'(ack3), 32'(1) << exp3[w]);
         for (int i = 0; i < int'(N); i++) if (ack1[i]) ack_cnt[i]++;
         tick();
         chk("fair_stb", 32'(stb1), 1);
         chk("fair_id", 32'(id1), 32'(exp1[w]));
         chk("fair_data", out1, 32'h1000 + 32'(exp1[w]));
         chk("burst_all_id", 32'(id3), 32'(exp3[w]));
         chk("burst_all_data", out3, 32'h1000 + 32'(exp3[w]));
         tick();
      end
      for (int i = 0; i < int'(N); i++) chk("fair_count", ack_cnt[i], 2);

      // Channels 0 and 1 only
      exp1 = '{0, 1, 0, 1, 0, 1, 0, 0};
      exp3 = '{1, 1, 1, 0, 0, 0, 1, 0};
      input_in_stb = 4'b0011;
      #1;
      for (int w = 0; w < 7; w++) begin
         chk("pair_ack", 32'(ack1), 32'(1) << exp1[w]);
         tick();
         chk("pair_id", 32'(id1), 32'(exp1[w]));
         chk("burst_pair_id", 32'(id3), 32'(exp3[w]));
         tick();
      end

      // Channel 0 takes one word of its burst, then drops; channel 1 wins at once
      input_in_stb = 4'b0001;
      #1;
      chk("drop_first_ack", 32'(ack3), 32'h1);
      tick();
      input_in_stb = 4'b0010;
      tick();
      chk("drop_ack", 32'(ack3), 32'h2);
      tick();
      chk("drop_id", 32'(id3), 1);
      input_in_stb = '0;
      tick();

      // Backpressure
      output_out_ack     = 1'b0;
      input_in[2*W +: W] = 32'hCAFEF00D;
      input_in_stb       = 4'b0100;
      #1;
      chk("bp_ack", 32'(ack1), 32'h4);
      tick();
      input_in_stb = 4'b1011;
      #1;
      for (int c = 0; c < 10; c++) begin
         chk("bp_stb", 32'(stb1), 1);
         chk("bp_data", out1, 32'hCAFEF00D);
         chk("bp_id", 32'(id1), 2);
         chk("bp_no_ack", 32'(ack1), 0);
         tick();
      end
      output_out_ack = 1'b1;
      tick();
      chk("bp_release_stb", 32'(stb1), 0);
      chk("bp_next_ack", 32'(ack1), 32'h8);
      input_in_stb = '0;
      tick();

      // Exceptions
      exception_in = 4'b0010;
      tick();
      exception_in = '0;
      chk("exc_set_src", 32'(src1), 32'h2);
      chk("exc_set_src_b3", 32'(src3), 32'h2);
      chk("exc_lag", 32'(exc1), 0);
      tick();
      chk("exc_high", 32'(exc1), 1);
      chk("exc_high_b3", 32'(exc3), 1);
      exception_in   = 4'b1000;
      exception_mask = 4'b1000;
      tick();
      exception_in = '0;
      chk("exc_masked", 32'(src1), 32'h2);
      exception_in  = 4'b0010;
      exception_clr = 1'b1;
      tick();
      exception_in = '0;
      chk("exc_set_wins", 32'(src1), 32'h2);
      tick();
      exception_clr = 1'b0;
      chk("exc_clear", 32'(src1), 0);
      chk("exc_clear_lag", 32'(exc1), 1);
      tick();
      chk("exc_low", 32'(exc1), 0);
      exception_in   = 4'b0001;
      exception_mask = '0;
      tick();
      exception_in   = '0;
      exception_mask = 4'b0001;
      tick();
      chk("exc_mask_keeps", 32'(src1), 32'h1);
      exception_clr = 1'b1;
      tick();
      exception_clr  = 1'b0;
      exception_mask = '0;
      chk("exc_clear2", 32'(src1), 0);
      tick();

      // Asynchronous reset during SEND
      output_out_ack     = 1'b0;
      input_in[1*W +: W] = 32'hA5A5A5A5;
      input_in_stb       = 4'b0010;
      exception_in       = 4'b0100;
      tick();
      input_in_stb = '0;
      exception_in = '0;
      #1;
      chk("rs_pre_stb", 32'(stb1), 1);
      chk("rs_pre_id", 32'(id1), 1);
      chk("rs_pre_src", 32'(src1), 32'h4);
      #2 rst = 1'b0;
      #1;
      chk("rs_stb", 32'(stb1), 0);
      chk("rs_out", out1, 0);
      chk("rs_id", 32'(id1), 0);
      chk("rs_src", 32'(src1), 0);
      tick();
      input_in_stb = 4'b1111;
      #1;
      chk("rs_ack_held", 32'(ack1), 0);
      tick();
      rst = 1'b1;
      #1;
      chk("rs_first_ack", 32'(ack1), 32'h1);
      chk("rs_first_ack_b3", 32'(ack3), 32'h1);
      tick();
      chk("rs_first_stb", 32'(stb1), 1);
      chk("rs_first_id", 32'(id1), 0);
      chk("rs_first_data", out1, 32'h1000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
